// File: rtl/sched_controller.sv
// rtl/sched_controller.sv - table-driven control word sequencer for the scheduled datapath
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, hold           run request (ignored while busy), issue stall
//   busy                  high whenever the sequencer is not idle
//   cfg_we/addr/data      control table write port (accepted only while idle)
//   cfg_err               one-cycle pulse after a write attempted while busy
//   alu1_*, mul1_*, log1_* registered operand selects and opcodes
//   reg_en                intermediate register enables
//   result_en, done_next  final result latch, datapath done-next-cycle
module sched_controller #(
    parameter int NUM_STEPS = 16,
    parameter int SEL_W     = 4,
    parameter int NUM_REGS  = 7,
    parameter int CW_W      = 38,
    parameter int AW        = $clog2(NUM_STEPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                hold,
    output logic                busy,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [CW_W-1:0]     cfg_data,
    output logic                cfg_err,
    output logic [SEL_W-1:0]    alu1_sel1,
    output logic [SEL_W-1:0]    alu1_sel2,
    output logic                alu1_op,
    output logic [SEL_W-1:0]    mul1_sel1,
    output logic [SEL_W-1:0]    mul1_sel2,
    output logic                mul1_op,
    output logic [SEL_W-1:0]    log1_sel1,
    output logic [SEL_W-1:0]    log1_sel2,
    output logic [1:0]          log1_op,
    output logic [NUM_REGS-1:0] reg_en,
    output logic                result_en,
    output logic                done_next
);

    // Field offsets inside a control word, LSB first.
    localparam int O_A1S1 = 0;
    localparam int O_A1S2 = SEL_W;
    localparam int O_A1OP = 2 * SEL_W;
    localparam int O_M1S1 = 2 * SEL_W + 1;
    localparam int O_M1S2 = 3 * SEL_W + 1;
    localparam int O_M1OP = 4 * SEL_W + 1;
    localparam int O_L1S1 = 4 * SEL_W + 2;
    localparam int O_L1S2 = 5 * SEL_W + 2;
    localparam int O_L1OP = 6 * SEL_W + 2;
    localparam int O_REG  = 6 * SEL_W + 4;
    localparam int O_RES  = O_REG + NUM_REGS;
    localparam int O_DN   = O_RES + 1;
    localparam int O_LAST = O_DN + 1;

    localparam logic [AW-1:0] LAST_STEP = AW'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_step;
    logic [AW-1:0]         w_step_nxt;
    logic [O_LAST-1:0]     r_out;
    logic [O_LAST-1:0]     w_out_nxt;
    logic                  r_cfg_err;
    logic [CW_W-1:0]       r_table [NUM_STEPS];
    logic [CW_W-1:0]       w_word;

    assign w_word = r_table[r_step];
    assign busy   = (r_state != IDLE);

    // State, step pointer and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_step    <= '0;
            r_out     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_out     <= w_out_nxt;
            r_cfg_err <= cfg_we && busy;
        end
    end

    // Control table; writes are only accepted while idle so a running
    // program never sees its own words change underneath it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_we && !busy) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_out_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_step_nxt  = '0;
                end
            end
            RUN: begin
                // A held cycle issues the idle word and keeps the step, so
                // the pending word goes out exactly once after the stall.
                if (!hold) begin
                    w_out_nxt = w_word[O_LAST-1:0];
                    // Wrap guard: the last table slot always ends the run.
                    if (w_word[O_LAST] || (r_step == LAST_STEP)) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
            end
            DRAIN: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
        endcase
    end

    assign cfg_err   = r_cfg_err;
    assign alu1_sel1 = r_out[O_A1S1 +: SEL_W];
    assign alu1_sel2 = r_out[O_A1S2 +: SEL_W];
    assign alu1_op   = r_out[O_A1OP];
    assign mul1_sel1 = r_out[O_M1S1 +: SEL_W];
    assign mul1_sel2 = r_out[O_M1S2 +: SEL_W];
    assign mul1_op   = r_out[O_M1OP];
    assign log1_sel1 = r_out[O_L1S1 +: SEL_W];
    assign log1_sel2 = r_out[O_L1S2 +: SEL_W];
    assign log1_op   = r_out[O_L1OP +: 2];
    assign reg_en    = r_out[O_REG +: NUM_REGS];
    assign result_en = r_out[O_RES];
    assign done_next = r_out[O_DN];

endmodule

// File: tb/tb_sched_controller.sv
// tb/tb_sched_controller.sv - randomized self-checking bench for sched_controller
module tb_sched_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        hold;
    logic        busy;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [37:0] cfg_data;
    logic        cfg_err;
    logic [3:0]  alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2;
    logic        alu1_op, mul1_op, result_en, done_next;
    logic [1:0]  log1_op;
    logic [6:0]  reg_en;

    sched_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hold      (hold),
        .busy      (busy),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .alu1_sel1 (alu1_sel1),
        .alu1_sel2 (alu1_sel2),
        .alu1_op   (alu1_op),
        .mul1_sel1 (mul1_sel1),
        .mul1_sel2 (mul1_sel2),
        .mul1_op   (mul1_op),
        .log1_sel1 (log1_sel1),
        .log1_sel2 (log1_sel2),
        .log1_op   (log1_op),
        .reg_en    (reg_en),
        .result_en (result_en),
        .done_next (done_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: table contents, the list of words the current run
    // still has to issue, and a coarse run phase (0 idle, 1 run, 2 drain).
    logic [37:0] m_tab [16];
    logic [36:0] m_q [$];
    int          m_phase = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] obs();
        return {done_next, result_en, reg_en, log1_op, log1_sel2, log1_sel1,
                mul1_op, mul1_sel2, mul1_sel1, alu1_op, alu1_sel2, alu1_sel1};
    endfunction

    // Program = table words from slot 0 up to and including the first
    // word flagged last, or the whole table if none is flagged.
    task automatic build_program();
        m_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_q.push_back(m_tab[i][36:0]);
            if (m_tab[i][37]) break;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tab[i] = '0;
        m_q.delete();
        m_phase = 0;
    endtask

    task automatic cycle(input logic st, input logic hd, input logic we,
                         input logic [3:0] ad, input logic [37:0] dt);
        logic [36:0] e_out;
        logic        e_err;
        @(negedge clk);
        start = st; hold = hd; cfg_we = we; cfg_addr = ad; cfg_data = dt;
        e_err = we && (m_phase != 0);
        e_out = '0;
        case (m_phase)
            0: begin
                if (we) m_tab[ad] = dt;
                if (st) begin
                    build_program();
                    m_phase = 1;
                end
            end
            1: begin
                if (!hd) begin
                    e_out = m_q.pop_front();
                    if (m_q.size() == 0) m_phase = 2;
                end
            end
            default: m_phase = 0;
        endcase
        @(posedge clk);
        #1;
        chk("out", 64'(obs()), 64'(e_out));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("cfg_err", 64'(cfg_err), 64'(e_err));
    endtask

    task automatic idle_inputs();
        start = 0; hold = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    endtask

    task automatic finish_run(input int hold_pct, input bit noise);
        for (int k = 0; k < 80 && m_phase != 0; k++) begin
            cycle(noise && ($urandom % 6 == 0), ($urandom % 100) < hold_pct,
                  noise && ($urandom % 6 == 0), 4'($urandom),
                  {6'($urandom), 32'($urandom)});
        end
        chk("run_bound", 64'(busy), 64'(0));
    endtask

    task automatic load(input logic [3:0] ad, input logic [37:0] dt);
        cycle(0, 0, 1, ad, dt);
    endtask

    function automatic logic [37:0] rnd_word(input int last_pct);
        logic [37:0] w;
        w = {6'($urandom), 32'($urandom)};
        w[37] = ($urandom % 100) < last_pct;
        return w;
    endfunction

    logic [37:0] w0, w1, w2;

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_out", 64'(obs()), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(cfg_err), 64'(0));

        // Empty table: 16 zero steps, busy for 17 cycles.
        cycle(1, 0, 0, 0, 0);
        finish_run(0, 0);

        // Three-step directed program.
        w0 = (38'h1 << 4) | (38'h1 << 28);
        w1 = (38'h8 << 9) | (38'h2 << 13) | (38'h1 << 30);
        w2 = (38'h1 << 26) | (38'h1 << 35) | (38'h1 << 36) | (38'h1 << 37);
        load(0, w0); load(1, w1); load(2, w2);
        cycle(1, 0, 0, 0, 0);
        finish_run(0, 0);

        // Hold two cycles after w0 issues.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        finish_run(0, 0);

        // Start with hold high is accepted; start mid-run is ignored.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        finish_run(0, 0);

        // Eight-step program; a write to slot 5 during a run is dropped.
        for (int i = 0; i < 8; i++) load(4'(i), rnd_word(i == 7 ? 100 : 0));
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 5, rnd_word(0));
        finish_run(0, 0);
        cycle(1, 0, 0, 0, 0);
        finish_run(20, 0);

        // Write and start on the same edge: the new word is used.
        cycle(1, 0, 1, 0, rnd_word(0));
        finish_run(0, 0);

        // Asynchronous reset while w1 is on the outputs.
        load(0, w0); load(1, w1); load(2, w2);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("w1_before_rst", 64'(obs()), 64'(w1[36:0]));
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_out", 64'(obs()), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        cycle(1, 0, 0, 0, 0);
        finish_run(0, 0);

        // Randomized tables, holds, stray starts and writes.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom % 2 == 0) load(4'(i), rnd_word(15));
            end
            cycle(1, 1'($urandom % 2), 0, 0, 0);
            finish_run(35, 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sched_controller.md
Name: sched_controller

Overview:
- Programmable control unit that drives the scheduled datapath.
- Holds a table of control words, one word per schedule step. The table is loaded through a config write port.
- On `start`, it plays the table back one step per clock. Each step produces the datapath's mux selects, FU opcodes, register enables, `result_en` and `done_next`.
- It is the producer end of the control interface that the datapath consumes. It sits between the top-level host handshake and the datapath.

Parameters:
- NUM_STEPS, 16: table depth; maximum steps per run.
- SEL_W, 4: width of each operand-select field.
- NUM_REGS, 7: number of intermediate-register enables.
- CW_W, 38: control word width. Must equal 6*SEL_W + 4 + NUM_REGS + 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the loaded schedule.
- hold  in  1  stall; while high, no step is issued.
- busy  out  1  high whenever state != IDLE.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(NUM_STEPS)  table write index.
- cfg_data  in  CW_W  control word to write.
- cfg_err  out  1  one-cycle pulse: write rejected.
- alu1_sel1, alu1_sel2  out  SEL_W  ALU operand selects.
- alu1_op  out  1  0 = ADD, 1 = SUB.
- mul1_sel1, mul1_sel2  out  SEL_W  multiplier operand selects.
- mul1_op  out  1  0 = MULT, 1 = DIV.
- log1_sel1, log1_sel2  out  SEL_W  logic unit operand selects.
- log1_op  out  2  00 = AND, 01 = OR, 10 = XOR.
- reg_en  out  NUM_REGS  bit order: alu2, alu5, mul6, mul9, log12, alu13, log14.
- result_en  out  1  latch final result.
- done_next  out  1  datapath done next cycle.

Behaviour:
- Control word layout, LSB first:
  - [3:0] alu1_sel1, [7:4] alu1_sel2, [8] alu1_op
  - [12:9] mul1_sel1, [16:13] mul1_sel2, [17] mul1_op
  - [21:18] log1_sel1, [25:22] log1_sel2, [27:26] log1_op
  - [34:28] reg_en, [35] result_en, [36] done_next
  - [37] last: the final step of the program
- All control outputs are registered.
- IDLE word = all zeros: every enable is 0; selects and ops are 0.
- Reset (rst_n low, asynchronous, also mid-run):
  - state = IDLE, step = 0, all outputs = 0, busy = 0, cfg_err = 0.
  - All table entries are cleared to 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start = 1 at an edge -> RUN, step = 0; outputs stay 0.
  - start with hold = 1 is still accepted.
- RUN, each edge:
  - If hold = 1: outputs <= 0, step unchanged. A held step is issued later, exactly once.
  - If hold = 0: outputs <= table[step].
    - If that word has last = 1, or step == NUM_STEPS-1 -> DRAIN.
    - Otherwise step <= step + 1.
- DRAIN, next edge: outputs <= 0 -> IDLE. hold is ignored in DRAIN.
- Latency for an N-step program with no holds:
  - start sampled at edge 0; word k is visible after edge k+1.
  - busy falls after edge N+1, the same edge at which the datapath's done rises.
- start while busy: ignored, no effect.
- cfg_we with busy = 0: table[cfg_addr] <= cfg_data at the edge.
- cfg_we with busy = 1: write dropped; cfg_err pulses high for the cycle after the edge.
- cfg_we and start on the same edge in IDLE: the write takes effect and the run starts. The word is visible to the run because the first issue happens one edge later.
- An all-zero table with start: runs NUM_STEPS steps of zero words, then IDLE (wrap guard; step never exceeds NUM_STEPS-1).

Test Plan:
- Reset, then read outputs -> all outputs 0, busy = 0. Start a run without loading -> 16 zero steps; busy high for 17 cycles.
- Load a 3-step program:
  - w0: alu1_sel1 = 0, alu1_sel2 = 1, reg_en = 0000001.
  - w1: mul1_sel1 = 8, mul1_sel2 = 2, reg_en bit 2.
  - w2: log1_op = 01, result_en = 1, done_next = 1, last = 1.
  - Pulse start -> w0/w1/w2 appear after edges 1/2/3; busy low after edge 4.
- Same program with hold high for 2 cycles after w0 issues -> two zero words, then w1 and w2. Each word is seen exactly once with enables asserted.
- cfg_we to address 5 during a run -> cfg_err = 1 for one cycle; readback by a later run shows address 5 unchanged.
- start pulsed again mid-run -> ignored; the sequence is unchanged.
- rst_n low while w1 is on the outputs -> outputs 0 immediately (asynchronous), state IDLE, table cleared; a new start issues zero words.
